// File: rtl/activation_reader.sv
`default_nettype none
// ============================================================================
// Module   : activation_reader
// Desc     : Streams accumulator rows from a register file and requantizes
//            each lane (arithmetic shift + 8-bit saturation) into an output
//            FIFO. Define ACT_RELU_EN for ReLU clamping to [0,255]; the
//            default build saturates signed to [-128,127].
// Revision : 1.0
// ============================================================================
module activation_reader #(
    parameter int MATRIX_WIDTH = 14,
    parameter int READ_LATENCY = 7,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [15:0]                 length,
    input  logic [4:0]                  shift,
    output logic [ADDR_WIDTH-1:0]       acc_read_addr,
    input  logic [MATRIX_WIDTH*32-1:0]  acc_data,
    output logic [MATRIX_WIDTH*8-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_CRD_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]      r_next_addr;
    logic [ADDR_WIDTH-1:0]      r_acc_addr;
    logic [15:0]                r_len;
    logic [15:0]                r_issue_cnt;
    logic [15:0]                r_pop_cnt;
    logic [4:0]                 r_shift;
    logic [READ_LATENCY-1:0]    r_tags;
    logic                       r_comp_vld;
    logic [MATRIX_WIDTH*8-1:0]  r_comp_data;
    logic [MATRIX_WIDTH*8-1:0]  w_act_row;
    logic [MATRIX_WIDTH*8-1:0]  r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;
    logic                       r_done;
    logic [c_CRD_W-1:0]         w_credits;

    logic w_fifo_valid;
    logic w_accept;
    logic w_zero_start;
    logic w_issue;
    logic w_last_issue;
    logic w_pop;
    logic w_push;
    logic w_last_pop;

    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && out_ready;
    assign w_push       = enable && r_comp_vld;
    assign w_accept     = start && (r_state == c_S_IDLE) && (length != 16'd0);
    assign w_zero_start = start && (r_state == c_S_IDLE) && (length == 16'd0);
    assign w_issue      = (r_state == c_S_ISSUE) && enable && (w_credits < c_CRD_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_issue_cnt == r_len - 16'd1);
    assign w_last_pop   = w_pop && (r_pop_cnt == r_len - 16'd1);

    // Every issued row owns a slot until popped; a pop on this edge frees one.
    always_comb begin
        w_credits = c_CRD_W'(r_count) + c_CRD_W'(r_comp_vld);
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_credits = w_credits + c_CRD_W'(r_tags[i]);
        end
        if (w_pop) begin
            w_credits = w_credits - c_CRD_W'(1);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_accept)     w_state_nxt = c_S_ISSUE;
            c_S_ISSUE: if (w_last_issue) w_state_nxt = c_S_DRAIN;
            c_S_DRAIN: if (w_last_pop)   w_state_nxt = c_S_IDLE;
            default:                     w_state_nxt = c_S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy          = (r_state != c_S_IDLE);
        done          = r_done;
        out_valid     = w_fifo_valid;
        out_data      = w_fifo_valid ? r_fifo[r_rd_ptr] : '0;
        acc_read_addr = r_acc_addr;
    end

    // ---------------- burst control and read issue ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_next_addr <= '0;
            r_acc_addr  <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_zero_start || ((r_state == c_S_DRAIN) && w_last_pop);
            if (w_accept) begin
                r_next_addr <= base_addr;
                r_len       <= length;
                r_shift     <= shift;
                r_issue_cnt <= '0;
                r_pop_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_acc_addr  <= r_next_addr;
                    r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                    r_issue_cnt <= r_issue_cnt + 16'd1;
                end
                if (w_pop) begin
                    r_pop_cnt <= r_pop_cnt + 16'd1;
                end
            end
        end
    end

    // Tag line mirrors the register file pipeline so capture lines up with data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tags      <= '0;
            r_comp_vld  <= 1'b0;
            r_comp_data <= '0;
        end else if (enable) begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_tags[i] <= r_tags[i-1];
            end
            r_tags[0]  <= w_issue;
            r_comp_vld <= r_tags[READ_LATENCY-1];
            if (r_tags[READ_LATENCY-1]) begin
                r_comp_data <= w_act_row;
            end
        end
    end

    // ---------------- per-lane requantization ----------------
    for (genvar g = 0; g < MATRIX_WIDTH; g++) begin : g_lane
        logic signed [31:0] w_word;
        logic signed [31:0] w_shifted;
        logic [7:0]         w_sat;

        assign w_word    = acc_data[g*32 +: 32];
        assign w_shifted = w_word >>> r_shift;

        always_comb begin
`ifdef ACT_RELU_EN
            if (w_shifted < 0) begin
                w_sat = 8'd0;
            end else if (w_shifted > 255) begin
                w_sat = 8'hFF;
            end else begin
                w_sat = w_shifted[7:0];
            end
`else
            if (w_shifted < -128) begin
                w_sat = 8'h80;
            end else if (w_shifted > 127) begin
                w_sat = 8'h7F;
            end else begin
                w_sat = w_shifted[7:0];
            end
`endif
        end

        assign w_act_row[g*8 +: 8] = w_sat;
    end

    // ---------------- output FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_comp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_activation_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation_reader
// Desc     : Self-checking bench for activation_reader with a register file
//            model; honours ACT_RELU_EN for the expected saturation rule.
// Revision : 1.0
// ============================================================================
module tb_activation_reader;

    localparam int MW     = 14;
    localparam int RL     = 7;
    localparam int DEPTH  = 8;
    localparam int AW     = 8;
    localparam int ROW_W  = MW * 8;
    localparam int WROW_W = MW * 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [15:0]       length = '0;
    logic [4:0]        shift = '0;
    logic [AW-1:0]     acc_read_addr;
    logic [WROW_W-1:0] acc_data;
    logic [ROW_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    activation_reader #(
        .MATRIX_WIDTH (MW),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .shift         (shift),
        .acc_read_addr (acc_read_addr),
        .acc_data      (acc_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Register file model: contents plus a stall-aware read pipeline.
    logic [WROW_W-1:0] mem [256];
    logic [WROW_W-1:0] rf_pipe [RL-1];

    always @(posedge clk) begin
        if (enable) begin
            rf_pipe[0] <= mem[acc_read_addr];
            for (int k = 1; k < RL - 1; k++) rf_pipe[k] <= rf_pipe[k-1];
        end
    end
    assign acc_data = rf_pipe[RL-2];

    int n_checks = 0;
    int n_errors = 0;
    logic [ROW_W-1:0] exp_q [$];

    typedef struct {
        logic [31:0] val;
        logic [4:0]  sh;
        logic [7:0]  exp_s;
        logic [7:0]  exp_r;
    } vec_t;
    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] act8(input logic [31:0] w, input int sh);
        longint v;
        v = longint'($signed(w)) >>> sh;
`ifdef ACT_RELU_EN
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
`else
        if (v < -128) return 8'h80;
        if (v > 127) return 8'h7F;
`endif
        return 8'(v);
    endfunction

    function automatic logic [ROW_W-1:0] act_row(input logic [WROW_W-1:0] r, input int sh);
        logic [ROW_W-1:0] res;
        for (int j = 0; j < MW; j++) res[j*8 +: 8] = act8(r[j*32 +: 32], sh);
        return res;
    endfunction

    function automatic logic [ROW_W-1:0] rep8(input logic [7:0] b);
        logic [ROW_W-1:0] res;
        for (int j = 0; j < MW; j++) res[j*8 +: 8] = b;
        return res;
    endfunction

    task automatic set_row(input int a, input logic [31:0] v);
        for (int j = 0; j < MW; j++) mem[a][j*32 +: 32] = v;
    endtask

    task automatic start_burst(input int base, input int len, input int sh);
        for (int i = 0; i < len; i++) exp_q.push_back(act_row(mem[(base + i) % 256], sh));
        base_addr = AW'(base);
        length    = 16'(len);
        shift     = 5'(sh);
        enable    = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Pops under random enable/ready until done, comparing rows in order.
    task automatic drain(input int en_pct, input int rdy_pct);
        int cyc;
        logic hold;
        logic [ROW_W-1:0] held;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        while (!done && cyc < 3000) begin
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk_row("hold_data", out_data, held);
            end
            enable    = ($urandom_range(99, 0) < en_pct);
            out_ready = ($urandom_range(99, 0) < rdy_pct);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_row: got %h expected none", out_data);
                end else begin
                    chk_row("row", out_data, exp_q.pop_front());
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
            tick();
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("rows_left", 64'(exp_q.size()), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        exp_q.delete();
        enable    = 1'b1;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        int cyc;
        int got;
        logic [AW-1:0] a0;
        logic [7:0] exp23 [4];

        for (int a = 0; a < 256; a++)
            for (int j = 0; j < MW; j++)
                mem[a][j*32 +: 32] = 32'($urandom_range(600, 0)) - 32'd300;
        for (int k = 0; k < RL - 1; k++) rf_pipe[k] = '0;

        vecs[0]  = '{32'd5,        5'd0,  8'h05, 8'h05};
        vecs[1]  = '{32'hFFFFFFFD, 5'd0,  8'hFD, 8'h00};
        vecs[2]  = '{32'd300,      5'd0,  8'h7F, 8'hFF};
        vecs[3]  = '{32'd7,        5'd0,  8'h07, 8'h07};
        vecs[4]  = '{32'd1024,     5'd2,  8'h7F, 8'hFF};
        vecs[5]  = '{32'd1020,     5'd2,  8'h7F, 8'hFF};
        vecs[6]  = '{32'd1019,     5'd2,  8'h7F, 8'hFE};
        vecs[7]  = '{32'hFFFFFFFF, 5'd5,  8'hFF, 8'h00};
        vecs[8]  = '{32'hFFFFFF00, 5'd1,  8'h80, 8'h00};
        vecs[9]  = '{32'hFFFFFEFE, 5'd1,  8'h80, 8'h00};
        vecs[10] = '{32'd254,      5'd1,  8'h7F, 8'h7F};
        vecs[11] = '{32'd256,      5'd1,  8'h7F, 8'h80};
        vecs[12] = '{32'h7FFFFFFF, 5'd31, 8'h00, 8'h00};
        vecs[13] = '{32'h80000000, 5'd31, 8'hFF, 8'h00};
        vecs[14] = '{32'hFFFFFFFB, 5'd1,  8'hFD, 8'h00};

        // Reset state
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(acc_read_addr), 64'd0);
        chk_row("rst_data", out_data, '0);
        tick();
        rst = 1'b1;
        tick();

        // Requantization table: one-row bursts, latency and done timing
        for (int k = 0; k < 15; k++) begin
            logic [7:0] e;
`ifdef ACT_RELU_EN
            e = vecs[k].exp_r;
`else
            e = vecs[k].exp_s;
`endif
            set_row(60 + k, vecs[k].val);
            out_ready = 1'b1;
            base_addr = AW'(60 + k);
            length    = 16'd1;
            shift     = vecs[k].sh;
            start     = 1'b1;
            tick();
            start = 1'b0;
            chk("tbl_busy", 64'(busy), 64'd1);
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("tbl_latency", 64'(cyc), 64'd9);
            chk_row("tbl_data", out_data, rep8(e));
            tick();
            chk("tbl_done", 64'(done), 64'd1);
            chk("tbl_busy_end", 64'(busy), 64'd0);
            chk("tbl_valid_end", 64'(out_valid), 64'd0);
            tick();
            chk("tbl_done_pulse", 64'(done), 64'd0);
        end
        out_ready = 1'b0;

        // Four-row burst, back-to-back rows at full throughput
        set_row(10, 32'd5);
        set_row(11, 32'hFFFFFFFD);
        set_row(12, 32'd300);
        set_row(13, 32'd7);
`ifdef ACT_RELU_EN
        exp23 = '{8'd5, 8'd0, 8'd255, 8'd7};
`else
        exp23 = '{8'd5, 8'hFD, 8'd127, 8'd7};
`endif
        out_ready = 1'b1;
        start_burst(10, 4, 0);
        exp_q.delete();
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("b4_latency", 64'(cyc), 64'd9);
        for (int i = 0; i < 4; i++) begin
            chk("b4_valid", 64'(out_valid), 64'd1);
            chk_row("b4_row", out_data, rep8(exp23[i]));
            chk("b4_no_early_done", 64'(done), 64'd0);
            tick();
        end
        chk("b4_done", 64'(done), 64'd1);
        out_ready = 1'b0;
        tick();

        // Back-pressure: credits cap outstanding reads at FIFO depth
        start_burst(120, 20, 0);
        repeat (40) tick();
        chk("bp_addr", 64'(acc_read_addr), 64'd127);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        repeat (5) tick();
        chk("bp_addr_hold", 64'(acc_read_addr), 64'd127);
        drain(100, 100);

        // Enable stall mid-burst freezes the address
        start_burst(30, 12, 1);
        repeat (3) tick();
        enable = 1'b0;
        a0 = acc_read_addr;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", 64'(acc_read_addr), 64'(a0));
        end
        enable = 1'b1;
        drain(100, 100);

        // Address wrap
        start_burst(255, 3, 0);
        tick();
        chk("wrap_a0", 64'(acc_read_addr), 64'd255);
        tick();
        chk("wrap_a1", 64'(acc_read_addr), 64'd0);
        tick();
        chk("wrap_a2", 64'(acc_read_addr), 64'd1);
        drain(100, 100);

        // Reset mid-burst, then a fresh short burst
        out_ready = 1'b1;
        start_burst(200, 10, 0);
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 100) begin
            if (out_valid) begin
                chk_row("rst_burst_row", out_data, exp_q.pop_front());
                got++;
            end
            tick();
            cyc++;
        end
        chk("rst_burst_rows", 64'(got), 64'd5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_addr", 64'(acc_read_addr), 64'd0);
        chk_row("mid_rst_data", out_data, '0);
        exp_q.delete();
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        start_burst(210, 2, 0);
        drain(100, 100);
        out_ready = 1'b1;
        repeat (15) tick();
        chk("post_rst_no_extra", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Zero-length start and start while busy
        a0 = acc_read_addr;
        base_addr = AW'(77);
        length    = 16'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_addr", 64'(acc_read_addr), 64'(a0));
        tick();
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_valid", 64'(out_valid), 64'd0);
        start_burst(40, 3, 0);
        tick();
        base_addr = AW'(90);
        length    = 16'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        drain(100, 100);

        // Randomized bursts against the reference queue
        for (int r = 0; r < 8; r++) begin
            start_burst(int'($urandom_range(255, 0)), int'($urandom_range(30, 1)),
                        int'($urandom_range(2, 0)));
            drain(75, 60);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/activation_reader.md
ACTIVATION_READER -- requirements
Module: activation_reader

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 14, lanes per accumulator row.
REQ-002 SHALL have parameter READ_LATENCY, default 7, enabled edges from register file read_addr sample to data_out valid.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >= 2), output FIFO entries and read-credit limit.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-low reset (one clock; reset asynchronous, active-low).
REQ-005 SHALL have ports: enable  in  1  global stall, shared with register file; start  in  1  begin burst; base_addr  in  accumulator_addr_type  first row; length  in  16  rows; shift  in  5  requantization right-shift.
REQ-006 SHALL have ports: acc_read_addr  out  accumulator_addr_type  to register file read_addr; acc_data  in  word_type[MATRIX_WIDTH]  from register file data_out.
REQ-007 SHALL have ports: out_data  out  byte_type[MATRIX_WIDTH]  activated row; out_valid  out  1; out_ready  in  1; busy  out  1; done  out  1  one-cycle pulse.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, DRAIN; IDLE->ISSUE on start with length>0; ISSUE->DRAIN after last address issued; DRAIN->IDLE when last row popped.
REQ-009 SHALL ignore start unless in IDLE; start with length=0 SHALL produce done in the next cycle with no reads and no FSM change.
REQ-010 SHALL issue one address per cycle in ISSUE, acc_read_addr = base_addr + i (modulo address width, wraps), i = 0..length-1, registered output.
REQ-011 SHALL issue only when enable=1 and credits (in-flight tags + compute stage + FIFO occupancy) < FIFO_DEPTH, counting same-edge pop.
REQ-012 SHALL track in-flight reads in a READ_LATENCY-bit valid shift line advancing only when enable=1; acc_data captured only when tag at final stage is set and enable=1.
REQ-013 SHALL apply per lane, one register stage: arithmetic right shift of signed 32-bit word by shift, then saturate to 8 bits per REQ-022, then push FIFO.
REQ-014 SHALL pop FIFO on out_valid && out_ready, independent of enable; out_data stable while out_valid && !out_ready.
REQ-015 SHALL give start-to-first-out_valid latency of READ_LATENCY+2 edges (9 default) with enable=1 and empty FIFO.
REQ-016 SHALL sustain one row per cycle when out_ready=1 and enable=1.
REQ-017 SHALL freeze issue, tags and compute stage while enable=0; FIFO drain continues.
REQ-018 SHALL drive busy=1 from start-accept edge until done edge inclusive of DRAIN; done pulses in the cycle after the last pop.
REQ-019 SHALL handle FIFO full with simultaneous push and pop as no occupancy change, no loss.

Reset
REQ-020 SHALL on rst=0 asynchronously clear FSM to IDLE, tags, credits, FIFO pointers, counters; out_valid=0, busy=0, done=0, acc_read_addr=0, out_data=0.
REQ-021 SHALL discard in-flight reads on reset mid-burst; stale register file data after reset SHALL never reach the FIFO.

Configuration
REQ-022 SHALL with macro ACT_RELU_EN defined clamp negatives to 0 and saturate to [0,255] unsigned; without it saturate signed to [-128,127] two's complement.

Verification
REQ-023 SHALL cover: base_addr=10, length=4, shift=0, rows 5,-3,300,7, out_ready=1 -> out_valid first at edge 9, data 5,0,255,7 (ACT_RELU_EN) / 5,-3,127,7 (off), done after 4th pop.
REQ-024 SHALL cover: length=20, out_ready=0 -> exactly 8 addresses issued, out_valid held, stall; out_ready=1 -> all 20 rows in order, no duplicates.
REQ-025 SHALL cover: enable=0 for 3 cycles mid-burst -> tag line and acc_read_addr frozen, rows match addresses, no loss.
REQ-026 SHALL cover: base_addr=max address, length=3 -> addresses max, 0, 1.
REQ-027 SHALL cover: rst=0 asserted at burst row 5 of 10 -> outputs cleared immediately; new start length=2 yields only 2 correct rows.
REQ-028 SHALL cover: start with length=0 -> done next cycle, busy=0, no acc_read_addr change; start during busy ignored.
